// File: rtl/rf_pkg.sv
// Shared defaults and helpers for the multi-ported register file.
package rf_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam int unsigned NREG_DEF     = 32;
  localparam int unsigned NRP_DEF      = 2;
  localparam int unsigned NWP_DEF      = 1;
  localparam bit          BYPASS_DEF   = 1'b1;
  localparam bit          ZERO_REG_DEF = 1'b1;

  function automatic int unsigned addr_w(input int unsigned nreg);
    return $clog2(nreg);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set by reserve, cleared by a committed write; reserve wins.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned NREG     = NREG_DEF,
  parameter bit          ZERO_REG = ZERO_REG_DEF,
  localparam int unsigned AW      = addr_w(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rsv_en,
  input  logic [AW-1:0]   rsv_addr,
  input  logic [NREG-1:0] wr_commit,
  output logic [NREG-1:0] busy
);

  logic [NREG-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int unsigned r = 0; r < NREG; r++) begin
      if (rsv_en && rsv_addr == AW'(r)) begin
        busy_d[r] = 1'b1;
      end else if (wr_commit[r]) begin
        busy_d[r] = 1'b0;
      end
    end
    if (ZERO_REG) begin
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Flop-based register file with NRP combinational read ports, NWP write ports and a busy scoreboard.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NREG     = NREG_DEF,
  parameter int unsigned NRP      = NRP_DEF,
  parameter int unsigned NWP      = NWP_DEF,
  parameter bit          BYPASS   = BYPASS_DEF,
  parameter bit          ZERO_REG = ZERO_REG_DEF,
  localparam int unsigned AW      = addr_w(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRP*AW-1:0]   rs_addr,
  output logic [NRP*XLEN-1:0] rs_data,
  output logic [NRP-1:0]      rs_busy,
  input  logic [NWP-1:0]      wr_en,
  input  logic [NWP*AW-1:0]   wr_addr,
  input  logic [NWP*XLEN-1:0] wr_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr
);

  logic [NREG-1:0] commit;
  logic [XLEN-1:0] cdata  [NREG];
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy;

  // Per-register write decode; later ports overwrite earlier ones, so the highest index wins.
  always_comb begin
    commit = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      cdata[r] = '0;
      for (int unsigned w = 0; w < NWP; w++) begin
        if (wr_en[w] && wr_addr[w*AW +: AW] == AW'(r)) begin
          commit[r] = 1'b1;
          cdata[r]  = wr_data[w*XLEN +: XLEN];
        end
      end
    end
    if (ZERO_REG) begin
      commit[0] = 1'b0;
      cdata[0]  = '0;
    end
    for (int unsigned r = 0; r < NREG; r++) begin
      regs_d[r] = commit[r] ? cdata[r] : regs_q[r];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        regs_q[r] <= regs_d[r];
      end
    end
  end

  rf_scoreboard #(
    .NREG     (NREG),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .wr_commit (commit),
    .busy      (busy)
  );

  // Outputs are forced to zero while reset is held so a bypassed write cannot leak through.
  always_comb begin
    rs_data = '0;
    rs_busy = '0;
    for (int unsigned p = 0; p < NRP; p++) begin
      logic [AW-1:0]   a;
      logic [XLEN-1:0] rd;
      logic            bz;
      a  = rs_addr[p*AW +: AW];
      rd = regs_q[a];
      bz = busy[a];
      if (BYPASS && commit[a]) begin
        rd = cdata[a];
        bz = 1'b0;
      end
      if (!rst) begin
        rd = '0;
        bz = 1'b0;
      end
      rs_data[p*XLEN +: XLEN] = rd;
      rs_busy[p]              = bz;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: instance A (NWP=2, bypass) and instance B (NWP=1, no bypass) side by side.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;

  logic [9:0]  a_rs_addr;
  logic [63:0] a_rs_data;
  logic [1:0]  a_rs_busy;
  logic [1:0]  a_wr_en;
  logic [9:0]  a_wr_addr;
  logic [63:0] a_wr_data;
  logic        a_rsv_en;
  logic [4:0]  a_rsv_addr;

  logic [9:0]  b_rs_addr;
  logic [63:0] b_rs_data;
  logic [1:0]  b_rs_busy;
  logic [0:0]  b_wr_en;
  logic [4:0]  b_wr_addr;
  logic [31:0] b_wr_data;
  logic        b_rsv_en;
  logic [4:0]  b_rsv_addr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_mp #(.NWP(2), .BYPASS(1'b1), .ZERO_REG(1'b1)) u_a (
    .clk(clk), .rst(rst),
    .rs_addr(a_rs_addr), .rs_data(a_rs_data), .rs_busy(a_rs_busy),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .rsv_en(a_rsv_en), .rsv_addr(a_rsv_addr)
  );

  regfile_mp #(.NWP(1), .BYPASS(1'b0), .ZERO_REG(1'b1)) u_b (
    .clk(clk), .rst(rst),
    .rs_addr(b_rs_addr), .rs_data(b_rs_data), .rs_busy(b_rs_busy),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    a_wr_en = '0; a_wr_addr = '0; a_wr_data = '0; a_rsv_en = 1'b0; a_rsv_addr = '0;
    b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0; b_rsv_en = 1'b0; b_rsv_addr = '0;
  endtask

  initial begin
    rst = 1'b0;
    a_rs_addr = '0;
    b_rs_addr = '0;
    idle();

    // Reset: bypass must not leak, and writes/reserves are discarded.
    @(negedge clk);
    a_wr_en = 2'b01; a_wr_addr[4:0] = 5'd5; a_wr_data[31:0] = 32'h1111_1111;
    a_rsv_en = 1'b1; a_rsv_addr = 5'd5;
    a_rs_addr[4:0] = 5'd5;
    #1;
    chk("rst_bypass_data", a_rs_data[31:0], 32'h0);
    chk("rst_bypass_busy", {31'b0, a_rs_busy[0]}, 32'h0);
    @(negedge clk);
    idle();
    #1;
    chk("rst_discard_write", a_rs_data[31:0], 32'h0);
    rst = 1'b1;
    #1;
    chk("post_rst_data", a_rs_data[31:0], 32'h0);
    chk("post_rst_busy", {30'b0, a_rs_busy}, 32'h0);

    // Write x5, read on port 1 next cycle.
    @(negedge clk);
    a_wr_en = 2'b01; a_wr_addr[4:0] = 5'd5; a_wr_data[31:0] = 32'hDEAD_BEEF;
    b_wr_en = 1'b1;  b_wr_addr = 5'd5;      b_wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    idle();
    a_rs_addr[9:5] = 5'd5;
    b_rs_addr[9:5] = 5'd5;
    #1;
    chk("a_x5_port1", a_rs_data[63:32], 32'hDEAD_BEEF);
    chk("b_x5_port1", b_rs_data[63:32], 32'hDEAD_BEEF);

    // Zero register: writes and reserves to x0 have no effect.
    @(negedge clk);
    a_wr_en = 2'b01; a_wr_addr[4:0] = 5'd0; a_wr_data[31:0] = 32'h0000_1234;
    a_rsv_en = 1'b1; a_rsv_addr = 5'd0;
    a_rs_addr[4:0] = 5'd0;
    #1;
    chk("x0_bypass", a_rs_data[31:0], 32'h0);
    @(negedge clk);
    idle();
    #1;
    chk("x0_read", a_rs_data[31:0], 32'h0);
    chk("x0_busy", {31'b0, a_rs_busy[0]}, 32'h0);

    // Same-cycle write/read of x7: forwarded on A, old value on B.
    @(negedge clk);
    a_wr_en = 2'b01; a_wr_addr[4:0] = 5'd7; a_wr_data[31:0] = 32'hA5A5_A5A5;
    b_wr_en = 1'b1;  b_wr_addr = 5'd7;      b_wr_data = 32'hA5A5_A5A5;
    a_rs_addr[4:0] = 5'd7;
    b_rs_addr[4:0] = 5'd7;
    #1;
    chk("a_x7_bypass", a_rs_data[31:0], 32'hA5A5_A5A5);
    chk("b_x7_nobypass", b_rs_data[31:0], 32'h0);
    @(negedge clk);
    idle();
    #1;
    chk("a_x7_after", a_rs_data[31:0], 32'hA5A5_A5A5);
    chk("b_x7_after", b_rs_data[31:0], 32'hA5A5_A5A5);

    // Two write ports to x3: port 1 wins, including on the bypass path.
    @(negedge clk);
    a_wr_en = 2'b11;
    a_wr_addr = {5'd3, 5'd3};
    a_wr_data = {32'h2, 32'h1};
    a_rs_addr[4:0] = 5'd3;
    #1;
    chk("x3_bypass_prio", a_rs_data[31:0], 32'h2);
    @(negedge clk);
    idle();
    #1;
    chk("x3_prio", a_rs_data[31:0], 32'h2);

    // Scoreboard on x9.
    @(negedge clk);
    a_rsv_en = 1'b1; a_rsv_addr = 5'd9;
    b_rsv_en = 1'b1; b_rsv_addr = 5'd9;
    a_rs_addr[4:0] = 5'd9;
    b_rs_addr[4:0] = 5'd9;
    #1;
    chk("a_x9_busy_before", {31'b0, a_rs_busy[0]}, 32'h0);
    @(negedge clk);
    idle();
    #1;
    chk("a_x9_busy_set", {31'b0, a_rs_busy[0]}, 32'h1);
    chk("b_x9_busy_set", {31'b0, b_rs_busy[0]}, 32'h1);
    @(negedge clk);
    a_wr_en = 2'b01; a_wr_addr[4:0] = 5'd9; a_wr_data[31:0] = 32'h0000_0077;
    a_rsv_en = 1'b1; a_rsv_addr = 5'd9;
    b_wr_en = 1'b1;  b_wr_addr = 5'd9;      b_wr_data = 32'h0000_0077;
    b_rsv_en = 1'b1; b_rsv_addr = 5'd9;
    #1;
    chk("a_x9_busy_bypass", {31'b0, a_rs_busy[0]}, 32'h0);
    chk("b_x9_busy_nobyp", {31'b0, b_rs_busy[0]}, 32'h1);
    @(negedge clk);
    idle();
    #1;
    chk("a_x9_rsv_wins", {31'b0, a_rs_busy[0]}, 32'h1);
    chk("b_x9_rsv_wins", {31'b0, b_rs_busy[0]}, 32'h1);
    chk("a_x9_data", a_rs_data[31:0], 32'h0000_0077);
    @(negedge clk);
    a_wr_en = 2'b01; a_wr_addr[4:0] = 5'd9; a_wr_data[31:0] = 32'h0000_0099;
    b_wr_en = 1'b1;  b_wr_addr = 5'd9;      b_wr_data = 32'h0000_0099;
    @(negedge clk);
    idle();
    #1;
    chk("a_x9_busy_clr", {31'b0, a_rs_busy[0]}, 32'h0);
    chk("b_x9_busy_clr", {31'b0, b_rs_busy[0]}, 32'h0);
    chk("b_x9_data", b_rs_data[31:0], 32'h0000_0099);

    // Load x1..x4, reserve x2, then asynchronous reset mid-cycle.
    @(negedge clk);
    a_wr_en = 2'b11; a_wr_addr = {5'd2, 5'd1}; a_wr_data = {32'h102, 32'h101};
    a_rsv_en = 1'b1; a_rsv_addr = 5'd2;
    @(negedge clk);
    idle();
    a_wr_en = 2'b11; a_wr_addr = {5'd4, 5'd3}; a_wr_data = {32'h104, 32'h103};
    @(negedge clk);
    idle();
    a_rs_addr = {5'd4, 5'd2};
    #1;
    chk("x2_loaded", a_rs_data[31:0], 32'h102);
    chk("x4_loaded", a_rs_data[63:32], 32'h104);
    chk("x2_busy", {31'b0, a_rs_busy[0]}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_x2", a_rs_data[31:0], 32'h0);
    chk("async_x4", a_rs_data[63:32], 32'h0);
    chk("async_busy", {30'b0, a_rs_busy}, 32'h0);
    b_rs_addr[4:0] = 5'd7;
    #1;
    chk("async_b_x7", b_rs_data[31:0], 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("after_rst_x2", a_rs_data[31:0], 32'h0);
    chk("after_rst_busy", {31'b0, a_rs_busy[0]}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  XLEN  32  data width in bits
  NREG  32  number of registers, a power of two, at least 2
  NRP   2   number of read ports
  NWP   1   number of write ports
  BYPASS  1  1 = a same-cycle write is forwarded to matching reads
  ZERO_REG  1  1 = register 0 reads 0, ignores writes, never busy
REQ-002 Ports (name, direction, width, meaning), one per line; AW = log2(NREG):
  clk  in  1  the single clock; rising edge
  rst  in  1  asynchronous, active-low reset
  rs_addr  in  NRP*AW  read addresses; port p occupies slice p
  rs_data  out  NRP*XLEN  read data; port p occupies slice p
  rs_busy  out  NRP  per-port flag: a pending write to that register is outstanding
  wr_en  in  NWP  per-port write enable
  wr_addr  in  NWP*AW  write addresses
  wr_data  in  NWP*XLEN  write data
  rsv_en  in  1  reserve request: mark a register as having a pending producer
  rsv_addr  in  AW  register to reserve

Function
REQ-003 Reads SHALL be combinational: rs_data[p] = reg[rs_addr[p]].
REQ-004 Writes SHALL commit on the rising edge of clk when wr_en[w]=1.
REQ-005 If several write ports target the same address in one cycle, the highest-indexed port SHALL win.
REQ-006 With ZERO_REG=1, a read of address 0 SHALL return 0 and a write to address 0 SHALL have no effect.
REQ-007 With BYPASS=1, a read whose address matches an enabled, non-ignored write in the same cycle SHALL return that write's data; the REQ-005 priority applies.
REQ-008 With BYPASS=0, a read SHALL return the pre-edge register contents.
REQ-009 Scoreboard: rsv_en=1 SHALL set busy[rsv_addr] at the next edge.
REQ-010 Scoreboard: a committed write to address a SHALL clear busy[a] at the next edge.
REQ-011 If a reserve and a write target the same address in the same cycle, the reserve SHALL win and busy stays set.
REQ-012 Reserving an already-busy register SHALL leave it busy; this is not an error.
REQ-013 rs_busy[p] = busy[rs_addr[p]], except it SHALL read 0 when BYPASS=1 and a same-cycle write to that address is present.
REQ-014 With ZERO_REG=1, busy[0] SHALL stay 0 permanently and a reserve of address 0 SHALL be ignored.
REQ-015 There SHALL be no other state and no handshake stall; every operation completes in one cycle.

Reset
REQ-016 rst=0 SHALL asynchronously clear all registers to 0 and all busy bits to 0.
REQ-017 While rst=0, rs_data SHALL read 0 and rs_busy SHALL read 0, whatever the inputs.
REQ-018 Writes and reserves presented during reset SHALL be discarded.
REQ-019 The first commit SHALL occur at the first rising edge after rst deasserts.

Structure
REQ-020 A shared package rf_pkg SHALL hold the default parameter values and an address-width helper function equal to log2(NREG).
REQ-021 The busy-bit logic SHALL be a sub-module named rf_scoreboard, with inputs rsv_en/rsv_addr and the write-commit vectors, and output busy[NREG].
REQ-022 The data array SHALL be flops; the block SHALL contain no latches.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
  - Write x5=0xDEADBEEF, then read x5 on port 1 in the next cycle -> rs_data[1]=0xDEADBEEF.
  - ZERO_REG=1: write x0=0x1234, then read x0 -> 0; reserve x0 -> rs_busy=0.
  - BYPASS=1: in the same cycle, write x7=0xA5A5A5A5 and read x7 -> 0xA5A5A5A5 immediately; with BYPASS=0 the same read returns the old value 0.
  - NWP=2: in one cycle, port 0 writes x3=1 and port 1 writes x3=2 -> x3 reads 2 afterwards.
  - Reserve x9 -> rs_busy=1 next cycle; then write x9 together with reserve x9 in one cycle -> still busy; then write alone -> busy clears.
  - Load x1..x4 and reserve x2, then pulse rst low mid-cycle -> all reads return 0 and rs_busy=0 immediately, with no clock edge needed.
